// File: rtl/arb_pkg.sv
// Shared types, sizes and the rotating-priority search used by the 4-way arbiter.
package arb_pkg;

   localparam int N_REQ        = 4;
   localparam int MAX_HOLD_DEF = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // Returns {found, index} of the first set request starting at ptr and wrapping.
   // Scanning from the far end lets the nearest hit overwrite the others.
   function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [1:0]       ptr);
      logic [1:0] idx;
      rr_pick = 3'b000;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (req[idx]) begin
            rr_pick = {1'b1, idx};
         end
      end
   endfunction

endpackage

// File: rtl/rr_arb_4_grant_decoder.sv
// 2-to-4 one-hot decoder with enable; turns the registered winner index into the grant bus.
module grant_decoder
   import arb_pkg::*;
(
   input  logic [1:0]       idx_i,
   input  logic             en_i,
   output logic [N_REQ-1:0] onehot_o
);

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_dec
         assign onehot_o[gi] = en_i && (idx_i == 2'(gi));
      end
   endgenerate

endmodule

// File: rtl/rr_arb_4.sv
// Four-requester round-robin arbiter with a hold limit and a one-cycle bubble between grants.
module rr_arb_4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [1:0]       grant_idx,
   output logic             grant_valid
);

   arb_state_e state_q, state_d;
   logic [1:0] ptr_q,   ptr_d;
   logic [3:0] hold_q,  hold_d;
   logic [1:0] idx_q,   idx_d;
   logic [2:0] pick;

   assign pick = rr_pick(req, ptr_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            hold_d = 4'd0;
            if (en && pick[2]) begin
               state_d = BUSY;
               idx_d   = pick[1:0];
               ptr_d   = pick[1:0] + 2'd1;
               hold_d  = 4'd1;
            end
         end
         BUSY: begin
            // Leaving BUSY always passes through IDLE, which forms the mandatory bubble.
            if (!en || !req[idx_q] || (hold_q >= 4'(MAX_HOLD))) begin
               state_d = IDLE;
               hold_d  = 4'd0;
            end else if (hold_q != 4'hF) begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         hold_q  <= 4'd0;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
      end
   end

   assign grant_valid = (state_q == BUSY);
   assign grant_idx   = idx_q;

   grant_decoder u_grant_decoder (
      .idx_i    (idx_q),
      .en_i     (grant_valid),
      .onehot_o (grant)
   );

endmodule

// File: tb/tb_rr_arb_4.sv
// Directed-vector bench for rr_arb_4 with hand-computed grant sequences.
module tb_rr_arb_4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   rr_arb_4 #(.MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] oh2idx(input logic [3:0] oh);
      oh2idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) oh2idx = 2'(i);
      end
   endfunction

   // Apply inputs for one rising edge, then check the outputs that edge produced.
   task automatic step(input string tag, input logic e, input logic [3:0] r,
                       input logic [3:0] exp_g);
      en  = e;
      req = r;
      @(posedge clk);
      @(negedge clk);
      $display("[TB] %s rst_n=%0b en=%0b req=%4b -> grant=%4b idx=%0d valid=%0b",
               tag, rst_n, e, r, grant, grant_idx, grant_valid);
      check({tag, "/grant"}, 32'(grant), 32'(exp_g));
      check({tag, "/valid"}, 32'(grant_valid), 32'(exp_g != 4'b0000));
      if (exp_g != 4'b0000) begin
         check({tag, "/idx"}, 32'(grant_idx), 32'(oh2idx(exp_g)));
      end
   endtask

   logic [3:0] rr_seq [21];

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      req   = 4'b0000;
      @(negedge clk);

      // Reset held two cycles with requests present: nothing granted.
      step("rst0", 1'b1, 4'b1111, 4'b0000);
      step("rst1", 1'b1, 4'b1111, 4'b0000);
      check("rst/idx", 32'(grant_idx), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step("noreq", 1'b1, 4'b0000, 4'b0000);

      // All requesting: 4-cycle holds, one bubble, rotate and wrap.
      rr_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
                 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                 4'b0001};
      for (int i = 0; i < 21; i++) step("rr_all", 1'b1, 4'b1111, rr_seq[i]);
      step("release", 1'b1, 4'b0000, 4'b0000);

      // Single requester for 3 cycles; index stays at last winner afterwards.
      for (int i = 0; i < 3; i++) step("req2", 1'b1, 4'b0100, 4'b0100);
      step("req2_off", 1'b1, 4'b0000, 4'b0000);
      check("req2_off/idx_hold", 32'(grant_idx), 32'd2);

      // Enable low blocks grants; dropping it mid-grant ends the grant.
      step("en_off0", 1'b0, 4'b1111, 4'b0000);
      step("en_off1", 1'b0, 4'b1111, 4'b0000);
      step("en_on", 1'b1, 4'b1111, 4'b1000);
      step("en_drop", 1'b0, 4'b1111, 4'b0000);

      // Reset mid-grant to requester 3, then ptr must restart at 0.
      step("g3", 1'b1, 4'b1000, 4'b1000);
      rst_n = 1'b0;
      step("rst_mid", 1'b1, 4'b1010, 4'b0000);
      check("rst_mid/idx", 32'(grant_idx), 32'd0);
      rst_n = 1'b1;
      step("post_rst", 1'b1, 4'b1010, 4'b0010);
      step("post_rst_rel", 1'b1, 4'b0000, 4'b0000);

      // Here ptr=2; a reset must bring it back to 0 so requester 1 beats 3.
      rst_n = 1'b0;
      step("rst_idle", 1'b1, 4'b0000, 4'b0000);
      rst_n = 1'b1;
      step("ptr_zero", 1'b1, 4'b1010, 4'b0010);
      step("ptr_zero_rel", 1'b1, 4'b0000, 4'b0000);

      // Grant to 3, release, then 1001 must pick requester 0 (wrap).
      step("g3b", 1'b1, 4'b1000, 4'b1000);
      step("g3b_rel", 1'b1, 4'b0000, 4'b0000);
      step("wrap", 1'b1, 4'b1001, 4'b0001);

      // Lone requester held: timeout, bubble, then re-grant to the same one.
      step("solo", 1'b1, 4'b0001, 4'b0001);
      step("solo", 1'b1, 4'b0001, 4'b0001);
      step("solo", 1'b1, 4'b0001, 4'b0001);
      step("solo_to", 1'b1, 4'b0001, 4'b0000);
      step("solo_again", 1'b1, 4'b0001, 4'b0001);
      step("solo_end", 1'b1, 4'b0000, 4'b0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/rr_arb_4.md
RR_ARB_4 -- requirements
Module: rr_arb_4

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, legal range 1..15: maximum consecutive cycles one requester may hold the grant.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port en, input, 1 bit: arbiter enable; 0 = no grants issued.
REQ-005 SHALL have port req, input, 4 bits: request lines, bit i = requester i.
REQ-006 SHALL have port grant, output, 4 bits: one-hot grant, 4'b0000 when nothing is granted.
REQ-007 SHALL have port grant_idx, output, 2 bits: binary index of the current or last winner.
REQ-008 SHALL have port grant_valid, output, 1 bit: high iff grant != 0.

Function
REQ-009 SHALL implement FSM with states IDLE and BUSY; grant_valid=1 exactly in BUSY.
REQ-010 SHALL keep a 2-bit priority pointer ptr; the search order is ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-011 SHALL, in IDLE with en=1 and req!=0 sampled at edge k, enter BUSY at edge k with grant_idx = first requesting index in search order; grant is visible in the cycle after edge k (1-cycle latency).
REQ-012 SHALL set ptr = winner+1 mod 4 at each grant, wrapping 3->0.
REQ-013 SHALL, in IDLE with en=0 or req=0, remain in IDLE with grant=0.
REQ-014 SHALL, in BUSY, keep grant stable while req[grant_idx]=1, en=1 and hold_cnt < MAX_HOLD.
REQ-015 SHALL return to IDLE, with grant=0 after the edge, when req[grant_idx]=0 is sampled in BUSY.
REQ-016 SHALL return to IDLE on the edge that would make the grant exceed MAX_HOLD consecutive cycles (timeout).
REQ-017 SHALL return to IDLE on any edge where en=0 is sampled in BUSY.
REQ-018 SHALL insert exactly one grant=0 bubble cycle between any two grants, including back-to-back grants to the same requester.
REQ-019 SHALL use a 4-bit hold_cnt: loaded with 1 on grant, incremented each BUSY cycle, saturating, and cleared in IDLE.
REQ-020 SHALL hold grant_idx at the last winner while in IDLE; grant_idx is meaningful only when grant_valid=1.
REQ-021 SHALL drive grant, grant_valid and grant_idx from registers only, with no combinational path from req or en to any output.
REQ-022 SHALL never assert more than one grant bit.

Reset
REQ-023 SHALL, while rst_n=0 at a rising edge, set state=IDLE, ptr=0, hold_cnt=0, grant_idx=0, grant=0 and grant_valid=0.
REQ-024 SHALL abort any grant when reset is asserted mid-BUSY: outputs are 0 after that edge and no grant is issued on that edge.
REQ-025 SHALL resume arbitration with ptr=0 on the first edge after rst_n returns high.

Structure
REQ-026 SHALL place the state enum, N_REQ=4 and the MAX_HOLD default in shared package arb_pkg.
REQ-027 SHALL instantiate one sub-module, grant_decoder: a 2-to-4 one-hot decoder with enable, driven by grant_idx and enable=grant_valid, producing grant.
REQ-028 SHALL keep the priority search combinational and the FSM, ptr and hold_cnt in one clocked process.

Verification
REQ-029 SHALL test: rst_n=0 for 2 cycles, then en=1, req=4'b0000 -> grant=0 and grant_valid=0 throughout.
REQ-030 SHALL test: MAX_HOLD=4, en=1, req=4'b1111 held -> grant 0001 x4, 0000, 0010 x4, 0000, 0100 x4, 0000, 1000 x4, 0000, 0001 (wrap).
REQ-031 SHALL test: req=4'b0100 high for 3 cycles from IDLE -> grant=0100 for 3 cycles starting one cycle after req rises, grant_idx=2, then 0000.
REQ-032 SHALL test: en=0 with req=4'b1111 -> grant=0; en dropped during BUSY -> grant=0 after the next edge.
REQ-033 SHALL test: rst_n=0 for one edge while grant=1000, then req=4'b1010 -> grant 0000 after the reset edge, then 0010 (ptr reset to 0).
REQ-034 SHALL test: grant to requester 3 released, then req=4'b1001 -> next grant 0001 (pointer wrap), not 1000.
